// File: rtl/latch_bank_pkg.sv
// Shared encodings for the latch_bank channel register bank.
// Mode and readback FSM state constants plus the per-cell control bundle.
package latch_bank_pkg;

    localparam logic [1:0] MODE_CAPTURE = 2'b00;
    localparam logic [1:0] MODE_HOLD    = 2'b01;
    localparam logic [1:0] MODE_SHIFT   = 2'b10;
    localparam logic [1:0] MODE_CLEAR   = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CAPT = 2'b01;
    localparam logic [1:0] ST_ACK  = 2'b10;

    typedef struct packed {
        logic load;
        logic clr;
    } cell_ctrl_t;

endpackage

// File: rtl/latch_bank_cell.sv
// One WIDTH-bit storage register with load/clear and a change-detect output.
// The change flag is high only when a write actually alters the stored value.
module latch_cell
    import latch_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  cell_ctrl_t       ctrl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             change
);

    logic [WIDTH-1:0] q_next;

    always_comb begin
        q_next = q;
        if (ctrl.clr) begin
            q_next = '0;
        end else if (ctrl.load) begin
            q_next = d;
        end
    end

    assign change = (ctrl.load | ctrl.clr) && (q_next != q);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/latch_bank.sv
// Bank of CHANNELS registers with capture/hold/shift/clear modes, sticky
// change flags and a request/acknowledge single-channel readback port.
//   state   | meaning
//   ST_IDLE | waiting for rd_req; latches rd_sel on accept
//   ST_CAPT | snapshot selected channel into rd_data, flag out-of-range
//   ST_ACK  | raise rd_ack next cycle, clear the channel's changed flag
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [WIDTH-1:0]          data,
    input  logic [1:0]                mode,
    output logic [CHANNELS*WIDTH-1:0] q_bus,
    output logic [CHANNELS-1:0]       changed,
    input  logic                      rd_req,
    input  logic [SEL_W-1:0]          rd_sel,
    output logic                      rd_ack,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_err
);

    logic [WIDTH-1:0]    cell_q [CHANNELS];
    logic [CHANNELS-1:0] cell_chg;
    logic [CHANNELS-1:0] ack_clr;
    logic [1:0]          state;
    logic [SEL_W-1:0]    sel;
    logic                sel_oob;

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            logic [WIDTH-1:0] shift_src;
            cell_ctrl_t       ctrl;

            // Shift chain: channel 0 takes the bus, others take their neighbour.
            if (g == 0) begin : g_head
                assign shift_src = data;
            end else begin : g_link
                assign shift_src = cell_q[g-1];
            end

            always_comb begin
                ctrl = '0;
                case (mode)
                    MODE_CAPTURE: ctrl.load = enable[g];
                    MODE_SHIFT:   ctrl.load = |enable;
                    MODE_CLEAR:   ctrl.clr  = enable[g];
                    default:      ctrl      = '0;
                endcase
            end

            latch_cell #(.WIDTH(WIDTH)) u_cell (
                .clk    (clk),
                .rst    (rst),
                .ctrl   (ctrl),
                .d      ((mode == MODE_SHIFT) ? shift_src : data),
                .q      (cell_q[g]),
                .change (cell_chg[g])
            );

            assign q_bus[g*WIDTH +: WIDTH] = cell_q[g];
        end
    endgenerate

    assign sel_oob = (int'(sel) >= CHANNELS);

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (state == ST_ACK && !rd_err && int'(sel) == i) begin
                ack_clr[i] = 1'b1;
            end
        end
    end

    // A fresh change in the same cycle as the readback clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            changed <= '0;
        end else begin
            changed <= cell_chg | (changed & ~ack_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sel     <= '0;
            rd_ack  <= 1'b0;
            rd_data <= '0;
            rd_err  <= 1'b0;
        end else begin
            rd_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_req) begin
                        sel    <= rd_sel;
                        rd_err <= 1'b0;
                        state  <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    if (sel_oob) begin
                        rd_data <= '0;
                        rd_err  <= 1'b1;
                    end else begin
                        rd_data <= cell_q[sel];
                        rd_err  <= 1'b0;
                    end
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    rd_ack <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/latch_bank.md
Name: latch_bank

Overview:
- Parametrised, clocked successor to the single-bit level-sensitive data latch.
- Holds CHANNELS independent WIDTH-bit storage registers. Each register is loaded from a shared data bus under a per-channel enable.
- Adds three operating modes beyond plain capture (hold-all, shift-chain, clear), a sticky per-channel change flag, and a request/acknowledge readback port.
- Sits between a shared data source and downstream consumers that either sample the registers in parallel or poll them one channel at a time.

Parameters:
- WIDTH, 8, bit width of each channel register and of the data bus.
- CHANNELS, 4, number of storage channels (>=2).
- SEL_W, 2, width of the readback channel select; must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  CHANNELS  per-channel load enable; bit i gates channel i.
- data  input  WIDTH  shared write data.
- mode  input  2  operating mode: 00 capture, 01 hold, 10 shift, 11 clear.
- q_bus  output  CHANNELS*WIDTH  all channel registers in parallel; channel i occupies bits [i*WIDTH +: WIDTH].
- changed  output  CHANNELS  sticky flag per channel: channel value changed since last readback.
- rd_req  input  1  readback request, sampled only in IDLE.
- rd_sel  input  SEL_W  channel to read, sampled with rd_req.
- rd_ack  output  1  single-cycle acknowledge.
- rd_data  output  WIDTH  snapshot of the selected channel; valid while rd_ack=1.
- rd_err  output  1  asserted with rd_ack when rd_sel >= CHANNELS.

Behaviour:
- Reset: rst=1 at a rising edge clears every channel register, changed, rd_ack, rd_data and rd_err to 0, and forces the FSM to IDLE. Reset overrides every mode and any read in progress.
- All register updates occur on the rising edge of clk. No combinational path exists from data to q_bus, so q_bus lags data by one cycle.
- mode=00 (capture): for each i with enable[i]=1, channel i <= data. Channels with enable[i]=0 hold their value.
- mode=01 (hold): all channels hold; enable is ignored.
- mode=10 (shift): gated by OR of enable.
  - Channel 0 <= data; channel i <= channel i-1 for i>=1.
  - The value in channel CHANNELS-1 is discarded.
  - If all enable bits are 0, all channels hold.
- mode=11 (clear): for each i with enable[i]=1, channel i <= 0. Other channels hold.
- changed[i] set condition: channel i is written this cycle and its next value differs from its current value. Writing an identical value does not set the flag.
- changed[i] clear condition: a readback of channel i completes (the cycle rd_ack=1 for rd_sel=i).
- Same-cycle set and clear on changed[i]: set wins, so the flag stays 1.
- Readback FSM:
  - IDLE: on rd_req=1, latch rd_sel and go to CAPT.
  - CAPT: snapshot the selected channel into rd_data (or load 0 and set rd_err if rd_sel is out of range); go to ACK.
  - ACK: rd_ack=1 for exactly one cycle, clear changed[sel] (unless rd_err=1); return to IDLE.
- Readback latency: rd_req sampled at edge N yields rd_ack high during the cycle after edge N+2.
- rd_req is ignored in CAPT and ACK; no queueing. A held rd_req re-triggers on return to IDLE.
- Snapshot timing: rd_data reflects the channel value at the CAPT edge. Writes during ACK do not alter rd_data.
- rd_data holds its last value after ACK. rd_err clears on the next accepted request.
- An out-of-range read (rd_sel >= CHANNELS) never modifies changed.

Decomposition:
- Shared package/include: mode encodings (MODE_CAPTURE=2'b00, MODE_HOLD=2'b01, MODE_SHIFT=2'b10, MODE_CLEAR=2'b11) and FSM state encodings (IDLE, CAPT, ACK).
- One natural sub-module, latch_cell: a single WIDTH-bit register with load/clear inputs and a change-detect output, instantiated CHANNELS times via generate.
- Mode decode and the readback FSM stay in latch_bank.

Test Plan:
- Reset and default state: assert rst for 2 cycles while driving data=8'hFF, enable=4'hF, mode=00 -> q_bus=0, changed=0, rd_ack=0 after release.
- Selective capture: mode=00, enable=4'b0101, data=8'hA5 for one cycle -> ch0=ch2=8'hA5, ch1=ch3=0, changed=4'b0101. Repeat the same data -> changed stays 4'b0101 with no new set.
- Hold and clear: mode=01 with data=8'h3C, enable=4'hF -> q_bus unchanged. Then mode=11, enable=4'b0001 -> ch0=0, ch2=8'hA5 retained.
- Shift chain: from reset, mode=10, enable=4'h1, data=1,2,3,4,5 on successive cycles -> q_bus = {ch3..ch0} = {8'h02,8'h03,8'h04,8'h05}; value 1 discarded.
- Readback and flag race:
  - Set changed[2]; pulse rd_req with rd_sel=2 -> rd_ack high on the 3rd cycle with rd_data=ch2 snapshot and changed[2] cleared.
  - Repeat while capturing new data into ch2 during ACK -> changed[2] remains 1.
- Out-of-range and busy request: CHANNELS=3, rd_sel=3 -> rd_ack=1, rd_err=1, rd_data=0, changed unchanged. A second rd_req issued during CAPT is ignored (only one rd_ack).
